// File: rtl/c_fetch_seq.sv
// c_fetch_seq: PC sequencer and fetch controller feeding the compressed-
// extension aligner/decoder. It runs the icache request/ack handshake, advances
// the halfword-aligned PC by 2 or 4, handles branch redirects and registers the
// aligned/expanded instruction toward decode (if2id).
//
// Optional feature: define C_FETCH_PERF_EN to add issue counters
// perf_comp_cnt_o / perf_full_cnt_o.
module c_fetch_seq #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    // redirect from execute
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    // icache handshake
    output logic        icache_req_o,
    output logic [31:0] icache_addr_o,
    input  logic        icache_ack_i,
    input  logic [31:0] icache_instr_i,
    // C-extension aligner/decoder
    output logic [31:0] pc_ff_o,
    output logic [31:0] instr_un_o,
    output logic        word_valid_o,
    input  logic        cext_stall_i,
    input  logic        cext_is_comp_i,
    input  logic [31:0] cext_instr_i,
    // decode
    input  logic        id_ready_i,
    output logic        if2id_valid_o,
    output logic [31:0] if2id_instr_o,
    output logic [31:0] if2id_pc_o
`ifdef C_FETCH_PERF_EN
    ,
    output logic [31:0] perf_comp_cnt_o,
    output logic [31:0] perf_full_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        KILL = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] req_addr;

    // Word address containing a byte/halfword address.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    // PC step by instruction size; plain 32-bit add wraps modulo 2^32.
    function automatic logic [31:0] pc_advance(input logic [31:0] pc, input logic comp);
        return pc + (comp ? 32'd2 : 32'd4);
    endfunction

    logic [31:0] br_pc;
    logic [31:0] br_addr;
    logic [31:0] next_pc;
    logic [31:0] next_word;
    logic [31:0] stall_addr;
    logic        slot_free;
    logic        issue;
    logic        reuse_word;

    // Redirect target: bit 0 is forced low, never trusted from execute.
    assign br_pc      = br_target_i & 32'hFFFF_FFFE;
    assign br_addr    = word_align(br_pc);
    assign next_pc    = pc_advance(pc_ff_o, cext_is_comp_i);
    assign next_word  = word_align(next_pc);
    // Straddling instruction: fetch the word after the one holding pc_ff_o.
    assign stall_addr = word_align(pc_ff_o) + 32'd4;
    assign slot_free  = !if2id_valid_o || id_ready_i;
    assign issue      = (state == HOLD) && !br_taken_i && !cext_stall_i && slot_free;
    // A compressed instruction in the lower half leaves the upper half in the
    // same word, so the next instruction starts there without a new fetch.
    assign reuse_word = cext_is_comp_i && !pc_ff_o[1];

    // Fetch FSM with all registered outputs, including the if2id register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pc_ff_o       <= RESET_VECTOR;
            req_addr      <= word_align(RESET_VECTOR);
            icache_addr_o <= word_align(RESET_VECTOR);
            icache_req_o  <= 1'b0;
            instr_un_o    <= 32'd0;
            word_valid_o  <= 1'b0;
            if2id_valid_o <= 1'b0;
            if2id_instr_o <= 32'd0;
            if2id_pc_o    <= 32'd0;
        end else begin
            // Decode drained the register and nothing replaces it this cycle.
            if (id_ready_i && !issue) begin
                if2id_valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (br_taken_i) begin
                        pc_ff_o       <= br_pc;
                        req_addr      <= br_addr;
                        icache_addr_o <= br_addr;
                        if2id_valid_o <= 1'b0;
                    end else begin
                        icache_addr_o <= req_addr;
                    end
                    icache_req_o <= 1'b1;
                    state        <= REQ;
                end

                REQ: begin
                    if (br_taken_i) begin
                        pc_ff_o       <= br_pc;
                        req_addr      <= br_addr;
                        if2id_valid_o <= 1'b0;
                        if (icache_ack_i) begin
                            // Old request completed: drop its data, re-request.
                            icache_addr_o <= br_addr;
                            state         <= REQ;
                        end else begin
                            // Outstanding request cannot be withdrawn; wait it out.
                            state <= KILL;
                        end
                    end else if (icache_ack_i) begin
                        instr_un_o   <= icache_instr_i;
                        word_valid_o <= 1'b1;
                        icache_req_o <= 1'b0;
                        state        <= HOLD;
                    end
                end

                KILL: begin
                    if (br_taken_i) begin
                        pc_ff_o       <= br_pc;
                        req_addr      <= br_addr;
                        if2id_valid_o <= 1'b0;
                    end
                    if (icache_ack_i) begin
                        // Stale data discarded; issue the redirected request.
                        icache_addr_o <= br_taken_i ? br_addr : req_addr;
                        state         <= REQ;
                    end
                end

                HOLD: begin
                    if (br_taken_i) begin
                        pc_ff_o       <= br_pc;
                        req_addr      <= br_addr;
                        icache_addr_o <= br_addr;
                        icache_req_o  <= 1'b1;
                        word_valid_o  <= 1'b0;
                        if2id_valid_o <= 1'b0;
                        state         <= REQ;
                    end else if (cext_stall_i) begin
                        // pc_ff_o holds; the C-extension keeps the lower half.
                        req_addr      <= stall_addr;
                        icache_addr_o <= stall_addr;
                        icache_req_o  <= 1'b1;
                        word_valid_o  <= 1'b0;
                        state         <= REQ;
                    end else if (slot_free) begin
                        if2id_valid_o <= 1'b1;
                        if2id_instr_o <= cext_instr_i;
                        if2id_pc_o    <= pc_ff_o;
                        pc_ff_o       <= next_pc;
                        if (!reuse_word) begin
                            req_addr      <= next_word;
                            icache_addr_o <= next_word;
                            icache_req_o  <= 1'b1;
                            word_valid_o  <= 1'b0;
                            state         <= REQ;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef C_FETCH_PERF_EN
    // Issue counters split by instruction size; free-running with wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_comp_cnt_o <= 32'd0;
            perf_full_cnt_o <= 32'd0;
        end else if (issue) begin
            if (cext_is_comp_i) begin
                perf_comp_cnt_o <= perf_comp_cnt_o + 32'd1;
            end else begin
                perf_full_cnt_o <= perf_full_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_c_fetch_seq.sv
// Directed bench for c_fetch_seq: reset, compressed pairs, uncompressed issue,
// straddle stall, redirect with kill, decode backpressure and address wrap.
module tb_c_fetch_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        br_taken_i = 1'b0;
    logic [31:0] br_target_i = 32'd0;
    logic        icache_req_o;
    logic [31:0] icache_addr_o;
    logic        icache_ack_i = 1'b0;
    logic [31:0] icache_instr_i = 32'd0;
    logic [31:0] pc_ff_o;
    logic [31:0] instr_un_o;
    logic        word_valid_o;
    logic        cext_stall_i = 1'b0;
    logic        cext_is_comp_i = 1'b0;
    logic [31:0] cext_instr_i = 32'd0;
    logic        id_ready_i = 1'b1;
    logic        if2id_valid_o;
    logic [31:0] if2id_instr_o;
    logic [31:0] if2id_pc_o;
`ifdef C_FETCH_PERF_EN
    logic [31:0] perf_comp_cnt_o;
    logic [31:0] perf_full_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    c_fetch_seq #(.RESET_VECTOR(32'h8000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .br_taken_i     (br_taken_i),
        .br_target_i    (br_target_i),
        .icache_req_o   (icache_req_o),
        .icache_addr_o  (icache_addr_o),
        .icache_ack_i   (icache_ack_i),
        .icache_instr_i (icache_instr_i),
        .pc_ff_o        (pc_ff_o),
        .instr_un_o     (instr_un_o),
        .word_valid_o   (word_valid_o),
        .cext_stall_i   (cext_stall_i),
        .cext_is_comp_i (cext_is_comp_i),
        .cext_instr_i   (cext_instr_i),
        .id_ready_i     (id_ready_i),
        .if2id_valid_o  (if2id_valid_o),
        .if2id_instr_o  (if2id_instr_o),
        .if2id_pc_o     (if2id_pc_o)
`ifdef C_FETCH_PERF_EN
        ,
        .perf_comp_cnt_o(perf_comp_cnt_o),
        .perf_full_cnt_o(perf_full_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        br_taken_i     = 1'b0;
        br_target_i    = 32'd0;
        icache_ack_i   = 1'b0;
        icache_instr_i = 32'd0;
        cext_stall_i   = 1'b0;
        cext_is_comp_i = 1'b0;
        cext_instr_i   = 32'd0;
        id_ready_i     = 1'b1;
    endtask

    // Reset, release, and step through IDLE; returns with the FSM in REQ.
    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Ack the outstanding request with a word; returns in HOLD.
    task automatic ack_word(input logic [31:0] w);
        icache_ack_i   = 1'b1;
        icache_instr_i = w;
        tick();
        icache_ack_i   = 1'b0;
        icache_instr_i = 32'd0;
    endtask

    initial begin
        // ---- reset values ----
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        check("rst_pc",        pc_ff_o,       32'h8000_0000);
        check("rst_req",       {31'd0, icache_req_o},  32'd0);
        check("rst_wvalid",    {31'd0, word_valid_o},  32'd0);
        check("rst_instr_un",  instr_un_o,    32'd0);
        check("rst_if2id_v",   {31'd0, if2id_valid_o}, 32'd0);
        check("rst_if2id_i",   if2id_instr_o, 32'd0);
        check("rst_if2id_pc",  if2id_pc_o,    32'd0);

        // ---- compressed pair in one word ----
        reset = 1'b0;
        tick();                                     // IDLE -> REQ
        check("s1_req",   {31'd0, icache_req_o}, 32'd1);
        check("s1_addr",  icache_addr_o, 32'h8000_0000);
        tick();                                     // no ack yet
        check("s1_req_hold", {31'd0, icache_req_o}, 32'd1);
        ack_word(32'h0001_4501);
        check("s1_instr_un", instr_un_o, 32'h0001_4501);
        check("s1_wvalid",   {31'd0, word_valid_o}, 32'd1);
        check("s1_req_drop", {31'd0, icache_req_o}, 32'd0);
        cext_is_comp_i = 1'b1;
        cext_instr_i   = 32'hAAAA_0001;
        tick();                                     // issue @ 8000_0000
        check("s1_i0_v",   {31'd0, if2id_valid_o}, 32'd1);
        check("s1_i0_pc",  if2id_pc_o,    32'h8000_0000);
        check("s1_i0_ins", if2id_instr_o, 32'hAAAA_0001);
        check("s1_pc2",    pc_ff_o,       32'h8000_0002);
        check("s1_noreq",  {31'd0, icache_req_o}, 32'd0);
        cext_instr_i = 32'hBBBB_0002;
        tick();                                     // issue @ 8000_0002
        check("s1_i1_pc",  if2id_pc_o,    32'h8000_0002);
        check("s1_i1_ins", if2id_instr_o, 32'hBBBB_0002);
        check("s1_pc4",    pc_ff_o,       32'h8000_0004);
        check("s1_req4",   {31'd0, icache_req_o}, 32'd1);
        check("s1_addr4",  icache_addr_o, 32'h8000_0004);
        check("s1_wv0",    {31'd0, word_valid_o}, 32'd0);
`ifdef C_FETCH_PERF_EN
        check("s1_perf_c", perf_comp_cnt_o, 32'd2);
        check("s1_perf_f", perf_full_cnt_o, 32'd0);
`endif
        cext_is_comp_i = 1'b0;
        tick();                                     // REQ, decode drains
        check("s1_drain",  {31'd0, if2id_valid_o}, 32'd0);

        // ---- uncompressed instruction ----
        do_reset();
        ack_word(32'h0000_0013);
        cext_is_comp_i = 1'b0;
        cext_instr_i   = 32'h0000_0013;
        tick();
        check("s2_pc",     if2id_pc_o,    32'h8000_0000);
        check("s2_ins",    if2id_instr_o, 32'h0000_0013);
        check("s2_nextpc", pc_ff_o,       32'h8000_0004);
        check("s2_addr",   icache_addr_o, 32'h8000_0004);
        check("s2_req",    {31'd0, icache_req_o}, 32'd1);

        // ---- straddling instruction at 8000_0002 ----
        do_reset();
        ack_word(32'h1234_4501);
        cext_is_comp_i = 1'b1;
        cext_instr_i   = 32'hCCCC_0001;
        tick();                                     // pc -> 8000_0002
        cext_is_comp_i = 1'b0;
        cext_stall_i   = 1'b1;
        tick();
        check("s3_stall_addr", icache_addr_o, 32'h8000_0004);
        check("s3_stall_req",  {31'd0, icache_req_o}, 32'd1);
        check("s3_stall_pc",   pc_ff_o,       32'h8000_0002);
        check("s3_stall_wv",   {31'd0, word_valid_o}, 32'd0);
        cext_stall_i = 1'b0;
        ack_word(32'h0000_5678);
        cext_instr_i = 32'h5678_1234;
        tick();
        check("s3_iss_pc",  if2id_pc_o,    32'h8000_0002);
        check("s3_iss_ins", if2id_instr_o, 32'h5678_1234);
        check("s3_nextpc",  pc_ff_o,       32'h8000_0006);
        check("s3_addr",    icache_addr_o, 32'h8000_0004);

        // ---- redirect during REQ without ack -> KILL ----
        do_reset();
        br_taken_i  = 1'b1;
        br_target_i = 32'h8000_0101;
        tick();
        br_taken_i  = 1'b0;
        check("s4_kill_pc",   pc_ff_o,       32'h8000_0100);
        check("s4_kill_req",  {31'd0, icache_req_o}, 32'd1);
        check("s4_kill_addr", icache_addr_o, 32'h8000_0000);
        check("s4_kill_v",    {31'd0, if2id_valid_o}, 32'd0);
        ack_word(32'hDEAD_BEEF);                    // stale ack
        check("s4_addr",    icache_addr_o, 32'h8000_0100);
        check("s4_req",     {31'd0, icache_req_o}, 32'd1);
        check("s4_discard", instr_un_o,    32'd0);
        check("s4_wv",      {31'd0, word_valid_o}, 32'd0);
        // redirect together with ack in REQ: stays in REQ, new address
        br_taken_i  = 1'b1;
        br_target_i = 32'h8000_0200;
        ack_word(32'hFEED_F00D);
        br_taken_i  = 1'b0;
        check("s4b_addr",  icache_addr_o, 32'h8000_0200);
        check("s4b_pc",    pc_ff_o,       32'h8000_0200);
        check("s4b_wv",    {31'd0, word_valid_o}, 32'd0);
        check("s4b_instr", instr_un_o,    32'd0);

        // ---- decode backpressure ----
        do_reset();
        ack_word(32'h0001_4501);
        cext_is_comp_i = 1'b1;
        cext_instr_i   = 32'h1111_0001;
        tick();                                     // issue @ 8000_0000
        id_ready_i   = 1'b0;
        cext_instr_i = 32'h2222_0002;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s5_bp_v",   {31'd0, if2id_valid_o}, 32'd1);
            check("s5_bp_ins", if2id_instr_o, 32'h1111_0001);
            check("s5_bp_pc",  pc_ff_o,       32'h8000_0002);
            check("s5_bp_req", {31'd0, icache_req_o}, 32'd0);
        end
        id_ready_i = 1'b1;
        tick();
        check("s5_res_pc",  if2id_pc_o,    32'h8000_0002);
        check("s5_res_ins", if2id_instr_o, 32'h2222_0002);
        check("s5_res_npc", pc_ff_o,       32'h8000_0004);
        check("s5_res_req", {31'd0, icache_req_o}, 32'd1);

        // ---- address wrap at top of memory ----
        do_reset();
        br_taken_i  = 1'b1;
        br_target_i = 32'hFFFF_FFFE;
        tick();                                     // KILL
        br_taken_i  = 1'b0;
        ack_word(32'h0);                            // stale ack -> REQ
        check("s6_addr", icache_addr_o, 32'hFFFF_FFFC);
        ack_word(32'h0013_0000);
        cext_stall_i = 1'b1;
        tick();
        cext_stall_i = 1'b0;
        check("s6_wrap", icache_addr_o, 32'h0000_0000);
        check("s6_pc",   pc_ff_o,       32'hFFFF_FFFE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
